// File: rtl/synth_pkg.sv
// Shared types and defaults for the polyphonic synth datapath.
package synth_pkg;

  localparam int RATE_WIDTH_DEF   = 24;
  localparam int SAMPLE_WIDTH_DEF = 16;
  localparam int AGE_WIDTH_DEF    = 8;

  typedef logic [6:0] note_t;

  typedef enum logic {
    MIX_AVG = 1'b0,
    MIX_SAT = 1'b1
  } mix_mode_e;

  typedef struct packed {
    logic                      on;
    note_t                     note;
    logic [RATE_WIDTH_DEF-1:0] rate;
    logic [AGE_WIDTH_DEF-1:0]  age;
  } voice_t;

endpackage

// File: rtl/voice_mixer.sv
// Two-stage voice mixer: gated wide sum, then average or saturate.
module voice_mixer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int MIX_MODE     = 0
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic [NUM_VOICES-1:0]              gate_in,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] sample_in,
  output logic [SAMPLE_WIDTH-1:0]            stream_out
);

  localparam int LW = $clog2(NUM_VOICES);
  localparam int AW = SAMPLE_WIDTH + LW;

  localparam logic signed [AW-1:0] SMAX =
    {{(LW+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {{(LW+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  logic signed [AW-1:0]           w_sum;
  logic signed [AW-1:0]           r_sum;
  logic        [SAMPLE_WIDTH-1:0] w_mix;
  logic        [SAMPLE_WIDTH-1:0] r_out;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (gate_in[i]) begin
        w_sum = w_sum + AW'($signed(
          sample_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
      end
    end
  end

  generate
    if (MIX_MODE == int'(MIX_SAT)) begin : g_sat
      always_comb begin
        w_mix = SAMPLE_WIDTH'(r_sum);
        if (r_sum > SMAX) w_mix = SAMPLE_WIDTH'(SMAX);
        else if (r_sum < SMIN) w_mix = SAMPLE_WIDTH'(SMIN);
      end
    end else begin : g_avg
      always_comb begin
        w_mix = SAMPLE_WIDTH'(r_sum >>> LW);
      end
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sum <= '0;
      r_out <= '0;
    end else begin
      r_sum <= w_sum;
      r_out <= w_mix;
    end
  end

  assign stream_out = r_out;

endmodule

// File: rtl/poly_voice_coordinator.sv
// Polyphonic voice allocator and mixer front-end.
// Define VOICE_STEAL_EN to steal the oldest voice when the pool is full.
module poly_voice_coordinator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int RATE_WIDTH   = RATE_WIDTH_DEF,
  parameter int AGE_WIDTH    = AGE_WIDTH_DEF,
  parameter int MIX_MODE     = 0
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic                               valid_in,
  input  logic                               is_note_on_in,
  input  logic [6:0]                         note_in,
  input  logic [RATE_WIDTH-1:0]              rate_in,
  input  logic                               panic_in,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_sample_in,
  output logic [NUM_VOICES-1:0]              voice_on_out,
  output logic [NUM_VOICES*RATE_WIDTH-1:0]   voice_rate_out,
  output logic [NUM_VOICES*7-1:0]            voice_note_out,
  output logic [NUM_VOICES-1:0]              retrig_out,
  output logic [SAMPLE_WIDTH-1:0]            stream_out,
  output logic                               drop_out
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  logic [NUM_VOICES-1:0] r_on;
  logic [NUM_VOICES-1:0] r_retrig;
  note_t                 r_note [NUM_VOICES];
  logic [RATE_WIDTH-1:0] r_rate [NUM_VOICES];
  logic [AGE_WIDTH-1:0]  r_age  [NUM_VOICES];
  logic                  r_drop;

  logic [NUM_VOICES-1:0] w_hit;
  logic [IW-1:0]         w_hit_idx;
  logic [IW-1:0]         w_free_idx;
  logic [IW-1:0]         w_tgt;
  logic                  w_any_hit;
  logic                  w_any_free;
  logic                  w_note_on;
  logic                  w_load;
  logic                  w_drop;
  logic                  w_off;

  // Descending scan leaves the lowest matching index.
  always_comb begin
    w_hit      = '0;
    w_hit_idx  = '0;
    w_free_idx = '0;
    w_any_free = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      w_hit[i] = r_on[i] && (r_note[i] == note_in);
      if (w_hit[i]) w_hit_idx = IW'(i);
      if (!r_on[i]) begin
        w_free_idx = IW'(i);
        w_any_free = 1'b1;
      end
    end
  end

  assign w_any_hit = |w_hit;

`ifdef VOICE_STEAL_EN
  logic [IW-1:0]        w_old_idx;
  logic [AGE_WIDTH-1:0] w_old_age;

  always_comb begin
    w_old_idx = '0;
    w_old_age = r_age[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (r_age[i] > w_old_age) begin
        w_old_age = r_age[i];
        w_old_idx = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    w_note_on = valid_in && is_note_on_in && !panic_in;
    w_off     = valid_in && !is_note_on_in && !panic_in && w_any_hit;
    w_load    = 1'b0;
    w_drop    = 1'b0;
    w_tgt     = '0;
    if (w_note_on) begin
      if (w_any_hit) begin
        w_load = 1'b1;
        w_tgt  = w_hit_idx;
      end else if (w_any_free) begin
        w_load = 1'b1;
        w_tgt  = w_free_idx;
      end else begin
`ifdef VOICE_STEAL_EN
        w_load = 1'b1;
        w_tgt  = w_old_idx;
`else
        w_drop = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_on     <= '0;
      r_retrig <= '0;
      r_drop   <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i] <= '0;
        r_rate[i] <= '0;
        r_age[i]  <= '0;
      end
    end else begin
      r_retrig <= '0;
      r_drop   <= 1'b0;
      if (panic_in) begin
        r_on <= '0;
        for (int i = 0; i < NUM_VOICES; i++) r_age[i] <= '0;
      end else begin
        r_drop <= w_drop;
        if (w_load) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IW'(i) == w_tgt) begin
              r_note[i]   <= note_in;
              r_rate[i]   <= rate_in;
              r_on[i]     <= 1'b1;
              r_age[i]    <= '0;
              r_retrig[i] <= 1'b1;
            end else if (r_on[i] && r_age[i] != AGE_MAX) begin
              r_age[i] <= r_age[i] + AGE_WIDTH'(1);
            end
          end
        end
        if (w_off) r_on[w_hit_idx] <= 1'b0;
      end
    end
  end

  assign voice_on_out = r_on;
  assign retrig_out   = r_retrig;
  assign drop_out     = r_drop;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign voice_rate_out[g*RATE_WIDTH +: RATE_WIDTH] = r_rate[g];
    assign voice_note_out[g*7 +: 7] = r_note[g];
  end

  voice_mixer #(
    .NUM_VOICES  (NUM_VOICES),
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .MIX_MODE    (MIX_MODE)
  ) u_mix (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .gate_in   (r_on),
    .sample_in (voice_sample_in),
    .stream_out(stream_out)
  );

endmodule

// File: tb/tb_poly_voice_coordinator.sv
// Scoreboard bench for poly_voice_coordinator, average and saturate mixers.
module tb_poly_voice_coordinator;

  localparam int NV = 4;
  localparam int SW = 16;
  localparam int RW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            valid;
  logic            is_on;
  logic [6:0]      note;
  logic [RW-1:0]   rate;
  logic            panic;
  logic [NV*SW-1:0] samples;

  logic [NV-1:0]    on0, on1, rt0, rt1;
  logic [NV*RW-1:0] rate0, rate1;
  logic [NV*7-1:0]  nt0, nt1;
  logic [SW-1:0]    st0, st1;
  logic             dr0, dr1;

  poly_voice_coordinator #(.NUM_VOICES(NV), .MIX_MODE(0)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid),
    .is_note_on_in(is_on), .note_in(note), .rate_in(rate),
    .panic_in(panic), .voice_sample_in(samples),
    .voice_on_out(on0), .voice_rate_out(rate0),
    .voice_note_out(nt0), .retrig_out(rt0),
    .stream_out(st0), .drop_out(dr0)
  );

  poly_voice_coordinator #(.NUM_VOICES(NV), .MIX_MODE(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid),
    .is_note_on_in(is_on), .note_in(note), .rate_in(rate),
    .panic_in(panic), .voice_sample_in(samples),
    .voice_on_out(on1), .voice_rate_out(rate1),
    .voice_note_out(nt1), .retrig_out(rt1),
    .stream_out(st1), .drop_out(dr1)
  );

  typedef struct {
    logic [NV-1:0]    on;
    logic [NV-1:0]    retrig;
    logic             drop;
    logic [NV*7-1:0]  notes;
    logic [NV*RW-1:0] rates;
  } exp_t;

  exp_t           exp_q[$];
  logic [SW-1:0]  mix0_q[$];
  logic [SW-1:0]  mix1_q[$];

  bit            m_on   [NV];
  logic [6:0]    m_note [NV];
  logic [RW-1:0] m_rate [NV];
  int            m_age  [NV];

  int checks = 0;
  int errors = 0;
  bit fix_smp = 0;

  function automatic logic [SW-1:0] mixexp(input int mode);
    int s;
    int r;
    logic signed [SW-1:0] v;
    s = 0;
    for (int i = 0; i < NV; i++) begin
      if (m_on[i]) begin
        v = samples[i*SW +: SW];
        s += int'(v);
      end
    end
    if (mode == 0) r = s >>> 2;
    else if (s > 32767) r = 32767;
    else if (s < -32768) r = -32768;
    else r = s;
    return r[SW-1:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_on[i] = 0; m_note[i] = '0; m_rate[i] = '0; m_age[i] = 0;
    end
    exp_q.delete(); mix0_q.delete(); mix1_q.delete();
  endtask

  task automatic cyc();
    exp_t e;
    exp_t g;
    int t;
    if (!fix_smp) samples = {$urandom(), $urandom()};
    mix0_q.push_back(mixexp(0));
    mix1_q.push_back(mixexp(1));
    e.retrig = '0;
    e.drop = 1'b0;
    if (panic) begin
      for (int i = 0; i < NV; i++) begin m_on[i] = 0; m_age[i] = 0; end
    end else if (valid && is_on) begin
      t = -1;
      for (int i = 0; i < NV; i++) if (m_on[i] && m_note[i] == note) t = i;
      if (t < 0)
        for (int i = NV - 1; i >= 0; i--) if (!m_on[i]) t = i;
      if (t < 0) begin
`ifdef VOICE_STEAL_EN
        t = 0;
        for (int i = 1; i < NV; i++) if (m_age[i] > m_age[t]) t = i;
`else
        e.drop = 1'b1;
`endif
      end
      if (t >= 0) begin
        for (int i = 0; i < NV; i++)
          if (i != t && m_on[i] && m_age[i] < 255) m_age[i]++;
        m_on[t] = 1; m_note[t] = note; m_rate[t] = rate; m_age[t] = 0;
        e.retrig[t] = 1'b1;
      end
    end else if (valid) begin
      for (int i = 0; i < NV; i++)
        if (m_on[i] && m_note[i] == note) m_on[i] = 0;
    end
    for (int i = 0; i < NV; i++) begin
      e.on[i] = m_on[i];
      e.notes[i*7 +: 7] = m_note[i];
      e.rates[i*RW +: RW] = m_rate[i];
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    valid = 1'b0;
    panic = 1'b0;
    g = exp_q.pop_front();
    checks++;
    if (on0 !== g.on) begin
      errors++; $display("FAIL voice_on got %b want %b", on0, g.on);
    end
    checks++;
    if (rt0 !== g.retrig) begin
      errors++; $display("FAIL retrig got %b want %b", rt0, g.retrig);
    end
    checks++;
    if (dr0 !== g.drop) begin
      errors++; $display("FAIL drop got %b want %b", dr0, g.drop);
    end
    checks++;
    if (nt0 !== g.notes) begin
      errors++; $display("FAIL notes got %h want %h", nt0, g.notes);
    end
    checks++;
    if (rate0 !== g.rates) begin
      errors++; $display("FAIL rates got %h want %h", rate0, g.rates);
    end
    checks++;
    if ({on1, rt1, dr1, nt1, rate1} !== {g.on, g.retrig, g.drop, g.notes, g.rates}) begin
      errors++;
      $display("FAIL state_sat got %h want %h", {on1, rt1, dr1, nt1, rate1},
               {g.on, g.retrig, g.drop, g.notes, g.rates});
    end
    if (mix0_q.size() >= 2) begin
      logic [SW-1:0] x0;
      logic [SW-1:0] x1;
      x0 = mix0_q.pop_front();
      x1 = mix1_q.pop_front();
      checks++;
      if (st0 !== x0) begin
        errors++; $display("FAIL stream_avg got %h want %h", st0, x0);
      end
      checks++;
      if (st1 !== x1) begin
        errors++; $display("FAIL stream_sat got %h want %h", st1, x1);
      end
    end
  endtask

  task automatic note_on(input logic [6:0] n, input logic [RW-1:0] r);
    valid = 1'b1; is_on = 1'b1; note = n; rate = r;
    cyc();
  endtask

  task automatic note_off(input logic [6:0] n);
    valid = 1'b1; is_on = 1'b0; note = n; rate = '0;
    cyc();
  endtask

  task automatic do_reset();
    valid = 1'b0; panic = 1'b0; fix_smp = 0;
    rst_n = 1'b0;
    #1;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    valid = 1'b0; panic = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({on0, rt0, dr0, st0, on1, st1} !== '0) begin
      errors++;
      $display("FAIL reset_ctl got %h want 0", {on0, rt0, dr0, st0, on1, st1});
    end
    checks++;
    if ({nt0, rate0} !== '0) begin
      errors++; $display("FAIL reset_regs got %h want 0", {nt0, rate0});
    end
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_first_note();
    do_reset();
    note_on(7'd60, 24'd2000);
    checks++;
    if (on0 !== 4'b0001 || rt0 !== 4'b0001) begin
      errors++; $display("FAIL first_on got %b/%b want 0001/0001", on0, rt0);
    end
    checks++;
    if (nt0[6:0] !== 7'd60 || rate0[RW-1:0] !== 24'd2000) begin
      errors++;
      $display("FAIL first_regs got %0d/%0d want 60/2000", nt0[6:0], rate0[RW-1:0]);
    end
    cyc();
  endtask

  task automatic test_alloc();
    do_reset();
    note_on(7'd60, 24'd100);
    note_on(7'd62, 24'd200);
    note_on(7'd64, 24'd300);
    note_on(7'd67, 24'd400);
    note_off(7'd62);
    checks++;
    if (on0 !== 4'b1101) begin
      errors++; $display("FAIL off62 got %b want 1101", on0);
    end
    note_off(7'd99);
    note_on(7'd69, 24'd500);
    checks++;
    if (on0 !== 4'b1111 || nt0[13:7] !== 7'd69 || rt0 !== 4'b0010) begin
      errors++;
      $display("FAIL reuse1 got %b/%0d/%b want 1111/69/0010", on0, nt0[13:7], rt0);
    end
  endtask

  task automatic test_retrig();
    do_reset();
    note_on(7'd60, 24'd2000);
    note_on(7'd62, 24'd2100);
    note_on(7'd60, 24'd1500);
    checks++;
    if (on0 !== 4'b0011 || rt0 !== 4'b0001 || rate0[RW-1:0] !== 24'd1500) begin
      errors++;
      $display("FAIL retrig60 got %b/%b/%0d want 0011/0001/1500",
               on0, rt0, rate0[RW-1:0]);
    end
  endtask

  task automatic test_full_pool();
    do_reset();
    note_on(7'd60, 24'd1);
    note_on(7'd62, 24'd2);
    note_on(7'd64, 24'd3);
    note_on(7'd67, 24'd4);
    note_on(7'd72, 24'd5);
`ifdef VOICE_STEAL_EN
    checks++;
    if (nt0[6:0] !== 7'd72 || dr0 !== 1'b0 || rt0 !== 4'b0001) begin
      errors++;
      $display("FAIL steal got %0d/%b/%b want 72/0/0001", nt0[6:0], dr0, rt0);
    end
`else
    checks++;
    if (nt0[6:0] !== 7'd60 || dr0 !== 1'b1 || on0 !== 4'b1111) begin
      errors++;
      $display("FAIL full_drop got %0d/%b/%b want 60/1/1111", nt0[6:0], dr0, on0);
    end
`endif
    note_on(7'd74, 24'd6);
    cyc();
  endtask

  task automatic test_mix();
    do_reset();
    note_on(7'd40, 24'd1);
    note_on(7'd41, 24'd1);
    note_on(7'd42, 24'd1);
    note_on(7'd43, 24'd1);
    fix_smp = 1;
    samples = {4{16'h7000}};
    cyc();
    cyc();
    checks++;
    if (st0 !== 16'h7000 || st1 !== 16'h7FFF) begin
      errors++; $display("FAIL mix_pos got %h/%h want 7000/7FFF", st0, st1);
    end
    samples = {4{16'h8000}};
    cyc();
    cyc();
    checks++;
    if (st0 !== 16'h8000 || st1 !== 16'h8000) begin
      errors++; $display("FAIL mix_neg got %h/%h want 8000/8000", st0, st1);
    end
    fix_smp = 0;
    note_off(7'd41);
    for (int i = 0; i < 6; i++) cyc();
  endtask

  task automatic test_panic();
    do_reset();
    note_on(7'd60, 24'd10);
    note_on(7'd62, 24'd20);
    panic = 1'b1;
    valid = 1'b1; is_on = 1'b1; note = 7'd50; rate = 24'd30;
    cyc();
    checks++;
    if (on0 !== 4'b0000 || rt0 !== 4'b0000 || dr0 !== 1'b0) begin
      errors++; $display("FAIL panic got %b/%b/%b want 0000/0000/0", on0, rt0, dr0);
    end
    note_on(7'd51, 24'd40);
    for (int i = 0; i < 4; i++) cyc();
    rst_n = 1'b0;
    #1;
    checks++;
    if (st0 !== '0 || st1 !== '0 || on0 !== '0) begin
      errors++; $display("FAIL midreset got %h/%h/%b want 0", st0, st1, on0);
    end
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      valid = 1'b1;
      is_on = ($urandom_range(0, 2) != 0);
      note  = 7'(60 + $urandom_range(0, 6));
      rate  = 24'($urandom_range(1, 5000));
      panic = ($urandom_range(0, 19) == 0);
      cyc();
    end
  endtask

  initial begin
    rst_n = 1'b1; valid = 1'b0; is_on = 1'b0; note = '0;
    rate = '0; panic = 1'b0; samples = '0;
    #3;
    test_reset();
    test_first_note();
    test_alloc();
    test_retrig();
    test_full_pool();
    test_mix();
    test_panic();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
